// File: rtl/crc5_frame_ctl_pkg.sv
// crc5_pkg: shared types and constants for the Gen2 CRC-5 frame controller.
// Holds the controller state enum, the CRC-5 polynomial taps, the preset and
// residue values, the nominal Query length, and the one-bit update function.
package crc5_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } crc5_state_e;

    localparam int         CRC5_W         = 5;
    // x^5 + x^3 + 1 with the x^5 term implicit: feedback lands on bits 3 and 0
    localparam logic [4:0] CRC5_POLY_TAPS = 5'b01001;
    localparam logic [4:0] CRC5_PRESET    = 5'b01001;
    localparam logic [4:0] CRC5_RESIDUE   = 5'b00000;
    localparam int         QUERY_LEN      = 22;

    // Advances the CRC register by one frame bit (MSB-first serial division)
    function automatic logic [4:0] crc5_next(input logic [4:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[4];
        return {crc[3:0], 1'b0} ^ (fb ? CRC5_POLY_TAPS : 5'b00000);
    endfunction

endpackage

// File: rtl/crc5_frame_ctl_if.sv
// crc5_frame_ctl_if: bit-stream and result bundle between the packet decoder /
// command FSM (master) and the CRC-5 frame controller (slave).
// Optional macro CRC5_ERRCNT_EN adds the err_clr / err_cnt pair.
interface crc5_frame_ctl_if;
    import crc5_pkg::*;

    logic              start;
    logic [4:0]        frame_len;
    logic              abort;
    logic              bit_valid;
    logic              bit_in;
    logic              busy;
    logic              crc_done;
    logic              crc_ok;
    logic [CRC5_W-1:0] crc;
    logic [4:0]        bit_cnt;
`ifdef CRC5_ERRCNT_EN
    logic              err_clr;
    logic [7:0]        err_cnt;
`endif

`ifdef CRC5_ERRCNT_EN
    modport master (
        output start, frame_len, abort, bit_valid, bit_in, err_clr,
        input  busy, crc_done, crc_ok, crc, bit_cnt, err_cnt
    );
    modport slave (
        input  start, frame_len, abort, bit_valid, bit_in, err_clr,
        output busy, crc_done, crc_ok, crc, bit_cnt, err_cnt
    );
`else
    modport master (
        output start, frame_len, abort, bit_valid, bit_in,
        input  busy, crc_done, crc_ok, crc, bit_cnt
    );
    modport slave (
        input  start, frame_len, abort, bit_valid, bit_in,
        output busy, crc_done, crc_ok, crc, bit_cnt
    );
`endif

endinterface

// File: rtl/crc5_shift.sv
// crc5_shift: 5-bit Gen2 CRC register, x^5+x^3+1, MSB-first.
// Synchronous load of the preset and a clock enable replace gating of the
// CRC clock/reset; load has priority over the enable.
module crc5_shift
    import crc5_pkg::*;
#(
    parameter logic [4:0] PRESET = CRC5_PRESET
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  logic       i_en,
    input  logic       i_bit,
    output logic [4:0] o_crc
);

    logic [4:0] r_crc;

    // Preset on reset or frame start, otherwise fold in one bit when enabled
    always_ff @(posedge clk) begin
        if (reset || i_load) begin
            r_crc <= PRESET;
        end else if (i_en) begin
            r_crc <= crc5_next(r_crc, i_bit);
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/crc5_frame_ctl.sv
// crc5_frame_ctl: sequences the CRC-5 check of one reader frame.
// Presets the CRC on start, shifts exactly frame_len bits, then checks the
// Gen2 residue and reports it with a one-cycle crc_done pulse.
// Optional macro CRC5_ERRCNT_EN adds a saturating failed-frame counter.
module crc5_frame_ctl
    import crc5_pkg::*;
#(
    parameter int         MAX_LEN    = 31,
    parameter logic [4:0] CRC_PRESET = CRC5_PRESET
) (
    input  logic                   clk,
    input  logic                   reset,
    crc5_frame_ctl_if.slave        bus
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_SHIFT = SHIFT;
    localparam logic [1:0] S_CHECK = CHECK;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_bitCnt;
    logic [CNT_W-1:0] r_len;
    logic             r_short;
    logic             r_ok;
    logic             r_done;

    logic             w_lenOk;
    logic             w_take;
    logic [CNT_W-1:0] w_bitCntNext;
    logic [4:0]       w_crc;

    // A frame shorter than its own CRC or longer than the counter range is
    // rejected up front and still reports a (failing) result.
    assign w_lenOk      = (bus.frame_len >= 5'd5) && (int'(bus.frame_len) <= MAX_LEN);
    assign w_take       = (r_state == S_SHIFT) && bus.bit_valid && !bus.start && !bus.abort;
    assign w_bitCntNext = r_bitCnt + 1'b1;

    crc5_shift #(
        .PRESET (CRC_PRESET)
    ) u_shift (
        .clk    (clk),
        .reset  (reset),
        .i_load (bus.start),
        .i_en   (w_take),
        .i_bit  (bus.bit_in),
        .o_crc  (w_crc)
    );

    // Frame sequencer: start wins over abort and over everything in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_bitCnt <= '0;
            r_len    <= '0;
            r_short  <= 1'b0;
            r_ok     <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.start) begin
                r_state  <= w_lenOk ? S_SHIFT : S_CHECK;
                r_bitCnt <= '0;
                r_len    <= CNT_W'(bus.frame_len);
                r_short  <= !w_lenOk;
                r_ok     <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_IDLE;
                    end
                    S_SHIFT: begin
                        if (bus.abort) begin
                            r_state <= S_IDLE;
                        end else if (w_take) begin
                            r_bitCnt <= w_bitCntNext;
                            if (w_bitCntNext == r_len) begin
                                r_state <= S_CHECK;
                            end
                        end
                    end
                    S_CHECK: begin
                        r_state <= S_IDLE;
                        if (!bus.abort) begin
                            r_ok   <= (w_crc == CRC5_RESIDUE) && !r_short;
                            r_done <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.busy     = (r_state == S_SHIFT) || (r_state == S_CHECK);
    assign bus.crc_done = r_done;
    assign bus.crc_ok   = r_ok;
    assign bus.crc      = w_crc;
    assign bus.bit_cnt  = 5'(r_bitCnt);

`ifdef CRC5_ERRCNT_EN
    logic [7:0] r_errCnt;

    // Count reported failures, saturating; a clear beats a same-cycle increment
    always_ff @(posedge clk) begin
        if (reset || bus.err_clr) begin
            r_errCnt <= 8'h00;
        end else if (r_done && !r_ok && (r_errCnt != 8'hFF)) begin
            r_errCnt <= r_errCnt + 8'h01;
        end
    end

    assign bus.err_cnt = r_errCnt;
`endif

endmodule

// File: tb/tb_crc5_frame_ctl.sv
// tb_crc5_frame_ctl: directed + randomized self-checking bench for crc5_frame_ctl.
// Expected CRCs come from a serial polynomial-division model of the frame.
// Honours CRC5_ERRCNT_EN when the design is built with it.
module tb_crc5_frame_ctl;
    import crc5_pkg::*;

    logic clk = 1'b0;
    logic reset;

    int checks    = 0;
    int failures  = 0;
    int doneCount = 0;
    int errExp    = 0;

    bit frameBits[32];

    crc5_frame_ctl_if bus();

    crc5_frame_ctl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Count every crc_done pulse mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (bus.crc_done === 1'b1) doneCount++;
    end

    // Remainder of the first n frame bits divided by x^5+x^3+1, preset 01001
    function automatic logic [4:0] refCrc(input int n);
        int r;
        int top;
        r = 9;
        for (int i = 0; i < n; i++) begin
            top = ((r >> 4) & 1) ^ int'(frameBits[i]);
            r   = (r << 1) & 31;
            if (top != 0) r = r ^ 9;
        end
        return 5'(r);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("[TB] check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startFrame(input int len);
        bus.start     = 1'b1;
        bus.frame_len = 5'(len);
        bus.bit_valid = 1'b1;
        bus.bit_in    = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.bit_valid = 1'b0;
    endtask

    task automatic applyStimulus(input int from, input int upto, input bit gapped);
        for (int i = from; i < upto; i++) begin
            if (gapped && i > from) begin
                bus.bit_valid = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
            end
            bus.bit_valid = 1'b1;
            bus.bit_in    = frameBits[i];
            tick();
        end
        bus.bit_valid = 1'b0;
    endtask

    task automatic waitDone(output int lat);
        lat = 0;
        while (bus.crc_done !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic buildGood(input int len);
        logic [4:0] c;
        for (int i = 0; i < len - 5; i++) frameBits[i] = 1'($urandom_range(0, 1));
        c = refCrc(len - 5);
        for (int i = 0; i < 5; i++) frameBits[len - 5 + i] = c[4 - i];
    endtask

    // Runs one legal-length frame and checks latency, verdict, crc and bit_cnt
    task automatic runFrame(input string tag, input int len, input bit gapped);
        int lat;
        logic [4:0] expCrc;
        expCrc = refCrc(len);
        startFrame(len);
        applyStimulus(0, len, gapped);
        waitDone(lat);
        checkOutput({tag, "_latency"}, lat, 1);
        checkOutput({tag, "_ok"}, bus.crc_ok, (expCrc == 5'd0) ? 1 : 0);
        checkOutput({tag, "_crc"}, bus.crc, expCrc);
        checkOutput({tag, "_bitcnt"}, bus.bit_cnt, len);
        if (expCrc != 5'd0) errExp++;
        tick();
        checkOutput({tag, "_done_one_cycle"}, bus.crc_done, 0);
        checkOutput({tag, "_idle_busy"}, bus.busy, 0);
    endtask

    initial begin
        int d0;
        int len;
        bit saved;
        bit good;

        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.frame_len = 5'd0;
        bus.abort     = 1'b0;
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b0;
`ifdef CRC5_ERRCNT_EN
        bus.err_clr   = 1'b0;
`endif

        repeat (3) tick();
        reset = 1'b0;
        checkOutput("reset_crc", bus.crc, 5'b01001);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_done", bus.crc_done, 0);
        checkOutput("reset_ok", bus.crc_ok, 0);
        checkOutput("reset_bitcnt", bus.bit_cnt, 0);
`ifdef CRC5_ERRCNT_EN
        checkOutput("reset_errcnt", bus.err_cnt, 0);
`endif

        for (int i = 0; i < 4; i++) begin
            bus.bit_valid = 1'($urandom_range(0, 1));
            bus.bit_in    = 1'($urandom_range(0, 1));
            tick();
        end
        bus.bit_valid = 1'b0;
        checkOutput("idle_bits_crc", bus.crc, 5'b01001);
        checkOutput("idle_bits_bitcnt", bus.bit_cnt, 0);

        buildGood(QUERY_LEN);
        startFrame(QUERY_LEN);
        checkOutput("start_busy", bus.busy, 1);
        checkOutput("start_preset", bus.crc, 5'b01001);
        applyStimulus(0, QUERY_LEN, 1'b0);
        checkOutput("lastbit_no_done_yet", bus.crc_done, 0);
        repeat (3) tick();
        checkOutput("good_model_residue", refCrc(QUERY_LEN), 0);

        runFrame("good", QUERY_LEN, 1'b0);

        saved        = frameBits[7];
        frameBits[7] = ~saved;
        runFrame("corrupt", QUERY_LEN, 1'b0);
        checkOutput("corrupt_crc_nonzero", (bus.crc != 5'd0) ? 1 : 0, 1);
`ifdef CRC5_ERRCNT_EN
        checkOutput("corrupt_errcnt", bus.err_cnt, errExp);
`endif
        frameBits[7] = saved;

        runFrame("gapped", QUERY_LEN, 1'b1);

        d0 = doneCount;
        startFrame(QUERY_LEN);
        applyStimulus(0, 10, 1'b0);
        runFrame("restart", QUERY_LEN, 1'b0);
        tick();
        checkOutput("restart_single_done", doneCount - d0, 1);

        d0 = doneCount;
        startFrame(QUERY_LEN);
        applyStimulus(0, 10, 1'b0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checkOutput("abort_busy", bus.busy, 0);
        checkOutput("abort_bitcnt_kept", bus.bit_cnt, 10);
        checkOutput("abort_crc_kept", bus.crc, refCrc(10));
        repeat (5) tick();
        checkOutput("abort_no_done", doneCount - d0, 0);
        checkOutput("abort_ok_cleared", bus.crc_ok, 0);

        startFrame(3);
        checkOutput("short_no_done_yet", bus.crc_done, 0);
        tick();
        checkOutput("short_done", bus.crc_done, 1);
        checkOutput("short_ok", bus.crc_ok, 0);
        checkOutput("short_bitcnt", bus.bit_cnt, 0);
        errExp++;
        tick();

        for (int k = 0; k < 6; k++) begin
            len  = $urandom_range(5, 31);
            good = 1'($urandom_range(0, 1));
            if (good) begin
                buildGood(len);
            end else begin
                for (int i = 0; i < len; i++) frameBits[i] = 1'($urandom_range(0, 1));
            end
            runFrame("random", len, 1'($urandom_range(0, 1)));
        end

`ifdef CRC5_ERRCNT_EN
        tick();
        checkOutput("final_errcnt", bus.err_cnt, errExp);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        checkOutput("errcnt_clear", bus.err_cnt, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/crc5_frame_ctl.md
# crc5_frame_ctl

Sequencer for the tag's CRC-5 check on incoming reader frames, e.g. Query, 22 bits including CRC.
- Sits between the demodulated bit stream from the packet decoder and the command FSM.
- Presets the CRC-5 register on frame start, shifts exactly the programmed number of bits, then checks the Gen2 residue.
- Reports pass/fail with a single-cycle done pulse.
- Replaces ad-hoc gating of the CRC clock and reset with one synchronous, clock-enabled controller.

## Interface
- MAX_LEN, default 31: maximum frame length in bits, CRC included. Sets the counter width as ceil(log2(MAX_LEN+1)).
- CRC_PRESET, default 5'b01001: Gen2 CRC-5 preset value.
- clk  in  1  single system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a new frame and latches frame_len.
- frame_len  in  5  bits in frame including 5 CRC bits; valid when start=1.
- abort  in  1  pulse; drop the current frame without a result.
- bit_valid  in  1  qualifies bit_in for one cycle.
- bit_in  in  1  frame bit, MSB first.
- busy  out  1  high in SHIFT and CHECK.
- crc_done  out  1  one-cycle pulse when the result is valid.
- crc_ok  out  1  result; held until the next start or reset.
- crc  out  5  live CRC register.
- bit_cnt  out  5  bits accepted in the current frame.

## Operation
- Polynomial x^5+x^3+1. On each accepted bit b, with fb = b ^ crc[4]:
  - crc[0] <= fb
  - crc[1] <= crc[0]
  - crc[2] <= crc[1]
  - crc[3] <= crc[2] ^ fb
  - crc[4] <= crc[3]
- Pass condition: crc == 5'b00000 after all frame_len bits, CRC included (Gen2 residue).
- FSM states:
  - IDLE: busy=0. On start, go to SHIFT: crc<=CRC_PRESET, bit_cnt<=0, len<=frame_len, crc_ok<=0.
  - SHIFT: on bit_valid, update crc and increment bit_cnt. When the accepted bit makes bit_cnt==len, go to CHECK.
  - CHECK: one cycle. crc_ok<=(crc==0), crc_done<=1, then go to IDLE.
- Short frames: if frame_len<5 or frame_len>MAX_LEN at start, go directly to CHECK with crc_ok forced to 0. No bits are consumed.
- start in SHIFT or CHECK restarts the frame (preset, latch new length). No crc_done is issued for the dropped frame.
- abort in SHIFT or CHECK returns to IDLE with no crc_done. crc and bit_cnt keep their values. abort in IDLE is ignored.
- start and abort in the same cycle: start wins.
- bit_valid in IDLE or CHECK is ignored. bit_valid in the same cycle as start is ignored; the first bit is taken the cycle after.
- bit_cnt does not wrap: length is bounded by len, so it cannot exceed MAX_LEN.

## Timing
- Reset values: crc=CRC_PRESET, bit_cnt=0, busy=0, crc_done=0, crc_ok=0, state IDLE.
- start at cycle T: crc shows the preset at T+1 and busy=1 at T+1.
- Last bit accepted at cycle T: state is CHECK at T+1, and crc_done/crc_ok are visible at T+2. crc_done is high for exactly one cycle.
- Throughput: one bit per cycle. Minimum frame-to-frame spacing is start to next start = frame_len + 2 cycles.
- reset mid-frame: all outputs return to their reset values on the next edge; no crc_done.

## Configuration
- CRC5_ERRCNT_EN defined:
  - Adds output err_cnt [7:0], reset to 0.
  - Increments on each crc_done with crc_ok=0, saturating at 8'hFF.
  - Adds input err_clr, a synchronous clear. When err_clr coincides with an increment, the counter clears.
- CRC5_ERRCNT_EN undefined: no err_cnt or err_clr ports, no counter logic.

## Structure
- Shared package crc5_pkg holds:
  - the state enum (IDLE, SHIFT, CHECK)
  - CRC5_POLY_TAPS
  - CRC5_PRESET = 5'b01001
  - CRC5_RESIDUE = 5'b00000
  - QUERY_LEN = 22
- One sub-module, crc5_shift: a 5-bit register with synchronous load (preset) and enable, using the update equations above. The controller instantiates it once.

## Test plan
- Reset then idle: reset 3 cycles -> crc=01001, busy=0, crc_done=0, crc_ok=0. Toggling bit_valid in IDLE leaves crc=01001.
- Good Query: start with frame_len=22, then 22 bits (17 payload + CRC5 from the bench model, back-to-back) -> crc_done exactly 2 cycles after the last bit, crc_ok=1, crc=00000, bit_cnt=22.
- Corrupted frame: same frame with bit 7 inverted -> crc_done pulse, crc_ok=0, crc!=00000. With CRC5_ERRCNT_EN, err_cnt=1.
- Gapped input: same good frame with bit_valid low for 1–3 random cycles between bits -> identical result to the back-to-back case.
- Restart and abort:
  - start again after 10 bits, then send the full good frame -> exactly one crc_done, crc_ok=1.
  - abort after 10 bits -> busy=0 next cycle and no crc_done.
- Short/illegal length: start with frame_len=3 -> crc_done 2 cycles later with crc_ok=0 and bit_cnt=0.
